// File: rtl/barrel_shifter.sv
// ---------------------------------------------------------------------------
// barrel_shifter
//
// Single-cycle registered logical-left barrel shifter used as the shift
// datapath element of the RISC16 ALU. The operand is shifted left by 0 to
// WIDTH-1 positions through a cascade of log2(WIDTH) 2:1 mux stages. Vacated
// LSBs are filled with zeros. The result is captured in an output register.
//
// Parameters:
//   WIDTH      operand/result width in bits (power of two, >= 2)
//
// Ports:
//   clk        rising-edge clock, sole clock domain
//   rst        synchronous active-high reset; clears Op on the next edge
//   Ip         operand to shift
//   shift_mag  unsigned shift amount, 0..WIDTH-1
//   Op         registered shift result, valid one clock after Ip/shift_mag
// ---------------------------------------------------------------------------
module barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           Ip,
    input  logic [$clog2(WIDTH)-1:0]   shift_mag,
    output logic [WIDTH-1:0]           Op
);

    // Shift-amount width follows from WIDTH, so it cannot drift out of
    // step with the operand width.
    localparam int SHW = $clog2(WIDTH);

    // stageVal[0] is the raw operand; stageVal[k+1] is the output of the
    // stage controlled by shift_mag[k]. stageVal[SHW] is the full result.
    logic [SHW:0][WIDTH-1:0] stageVal;
    logic [WIDTH-1:0]        opD;
    logic [WIDTH-1:0]        opQ;

    // Mux cascade. Stages run from the LSB of shift_mag upward, so stage k
    // moves the value by 2^k positions when its control bit is set and
    // passes it through otherwise. The << operator brings in zeros at the
    // bottom and drops bits pushed past the MSB, which is exactly the
    // logical-shift behaviour we want. Because each stage is a plain mux,
    // an unknown operand bit only pollutes the result bits it lands on.
    always_comb begin
        stageVal    = '0;
        stageVal[0] = Ip;
        for (int k = 0; k < SHW; k++) begin
            if (shift_mag[k]) begin
                stageVal[k+1] = stageVal[k] << (2 ** k);
            end else begin
                stageVal[k+1] = stageVal[k];
            end
        end
    end

    // Next-state value for the output register is simply the end of the
    // cascade; every cycle is an operation, so there is no enable.
    always_comb begin
        opD = stageVal[SHW];
    end

    // Output register. Reset is synchronous and wins over the data load,
    // so a cycle with rst high always produces zero regardless of inputs.
    // Dropping rst lets the very next edge load a real result.
    always_ff @(posedge clk) begin
        if (rst) begin
            opQ <= '0;
        end else begin
            opQ <= opD;
        end
    end

    assign Op = opQ;

endmodule

// File: tb/tb_barrel_shifter.sv
// ---------------------------------------------------------------------------
// tb_barrel_shifter
//
// Directed and random checks for barrel_shifter (WIDTH = 8). Inputs are
// driven just after a rising edge. Op is sampled 1 time unit after the
// following edge, which is where the result for those inputs should appear.
// ---------------------------------------------------------------------------
module tb_barrel_shifter;

    logic       clk;
    logic       rst;
    logic [7:0] Ip;
    logic [2:0] shift_mag;
    logic [7:0] Op;

    int testCount;
    int failCount;

    barrel_shifter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .Ip        (Ip),
        .shift_mag (shift_mag),
        .Op        (Op)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one set of inputs, then advance past the next rising edge so
    // the registered result for those inputs is visible on Op.
    task automatic applyStimulus(input logic r, input logic [7:0] ip, input logic [2:0] sh);
        rst       = r;
        Ip        = ip;
        shift_mag = sh;
        @(posedge clk);
        #1;
    endtask

    // Compare Op against a value the bench worked out for itself.
    task automatic checkOutput(input string tag, input logic [7:0] expected);
        testCount++;
        assert (Op === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, Op, expected);
        end
    endtask

    // Independent reference: widen, shift, keep the low byte.
    function automatic logic [7:0] refShift(input logic [7:0] ip, input logic [2:0] sh);
        logic [15:0] wide;
        wide = {8'h00, ip} << sh;
        return wide[7:0];
    endfunction

    initial begin
        logic [7:0] walkExp [8];
        logic [7:0] rIp;
        logic [2:0] rSh;
        logic [7:0] rExp;

        testCount = 0;
        failCount = 0;
        rst       = 1'b1;
        Ip        = 8'h00;
        shift_mag = 3'd0;
        @(posedge clk);
        #1;

        // Reset held for two edges with non-zero data on the inputs.
        applyStimulus(1'b1, 8'hFF, 3'd3);
        checkOutput("reset_edge1", 8'h00);
        applyStimulus(1'b1, 8'hFF, 3'd3);
        checkOutput("reset_edge2", 8'h00);

        // First edge after release loads a real result.
        applyStimulus(1'b0, 8'hFF, 3'd3);
        checkOutput("release_ff_sh3", 8'hF8);

        // Directed shifts of 8'b11010101.
        applyStimulus(1'b0, 8'hD5, 3'd0);
        checkOutput("d5_sh0", 8'hD5);
        applyStimulus(1'b0, 8'hD5, 3'd1);
        checkOutput("d5_sh1", 8'hAA);
        applyStimulus(1'b0, 8'hD5, 3'd2);
        checkOutput("d5_sh2", 8'h54);
        applyStimulus(1'b0, 8'hD5, 3'd4);
        checkOutput("d5_sh4", 8'h50);
        applyStimulus(1'b0, 8'hD5, 3'd3);
        checkOutput("d5_sh3", 8'hA8);
        applyStimulus(1'b0, 8'hD5, 3'd5);
        checkOutput("d5_sh5", 8'hA0);
        applyStimulus(1'b0, 8'hD5, 3'd6);
        checkOutput("d5_sh6", 8'h40);
        applyStimulus(1'b0, 8'hD5, 3'd7);
        checkOutput("d5_sh7", 8'h80);

        // Input changes between edges must not disturb the held result.
        Ip        = 8'h3C;
        shift_mag = 3'd2;
        #3;
        checkOutput("hold_between_edges", 8'h80);

        // Raising rst between edges has no effect until the next edge.
        rst = 1'b1;
        #2;
        checkOutput("sync_reset_no_async", 8'h80);
        @(posedge clk);
        #1;
        checkOutput("sync_reset_takes_edge", 8'h00);

        // Single-bit walk, back to back.
        walkExp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h01, 3'(i));
            checkOutput($sformatf("walk_sh%0d", i), walkExp[i]);
        end

        // Walk again with a one-cycle reset pulse in the middle.
        applyStimulus(1'b0, 8'h01, 3'd1);
        checkOutput("walk2_sh1", 8'h02);
        applyStimulus(1'b0, 8'h01, 3'd2);
        checkOutput("walk2_sh2", 8'h04);
        applyStimulus(1'b1, 8'h01, 3'd3);
        checkOutput("walk2_reset_pulse", 8'h00);
        applyStimulus(1'b0, 8'h01, 3'd4);
        checkOutput("walk2_after_reset", 8'h10);
        applyStimulus(1'b0, 8'h01, 3'd5);
        checkOutput("walk2_sh5", 8'h20);

        // Maximum shift leaves only Ip[0] in the MSB.
        applyStimulus(1'b0, 8'hFE, 3'd7);
        checkOutput("max_shift_lsb0", 8'h00);
        applyStimulus(1'b0, 8'h7F, 3'd7);
        checkOutput("max_shift_lsb1", 8'h80);

        // Random operands and shift amounts.
        for (int n = 0; n < 1000; n++) begin
            rIp  = 8'($urandom_range(0, 255));
            rSh  = 3'($urandom_range(0, 7));
            rExp = refShift(rIp, rSh);
            applyStimulus(1'b0, rIp, rSh);
            checkOutput("random", rExp);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/barrel_shifter.md
# barrel_shifter

Single-cycle registered logical-left barrel shifter. It shifts an 8-bit operand left by 0–7 positions and fills vacated LSBs with zeros. It is the shift datapath element of the RISC16 ALU. The shift is computed combinationally through log2(WIDTH) mux stages and captured in an output register.

## Interface
- WIDTH, 8, operand/result width in bits; must be a power of two ≥ 2.
- SHW, log2(WIDTH) = 3, shift-amount width; derived, not overridden independently.

- clk  input  1  rising-edge clock; sole clock domain.
- rst  input  1  reset, synchronous and active-high; sampled on rising clk edge.
- Ip  input  WIDTH  operand to shift.
- shift_mag  input  SHW  unsigned shift amount, 0..WIDTH-1.
- Op  output  WIDTH  registered shift result.

## Operation
- Logical left shift: Op = (Ip << shift_mag) truncated to WIDTH bits.
- Bits shifted out of the MSB are discarded. Vacated LSBs are filled with 0.
- No rotate, arithmetic, or right-shift modes.
- Structure: SHW cascaded stages. Stage k shifts left by 2^k when shift_mag[k]=1 and passes through otherwise.
  - Stage order: LSB of shift_mag first (1, then 2, then 4).
  - Each stage is a WIDTH-wide 2:1 mux with zero insertion.
- shift_mag = 0 passes Ip through unchanged.
- shift_mag = WIDTH-1 leaves only Ip[0], in the MSB position.
- Every shift_mag encoding is in range, so no saturation or error path exists.
- X on any Ip bit propagates only to the result bits it reaches. No other masking is required.

## Timing
- Latency: 1 clock. Op on the rising edge after sampling equals the shift of the Ip/shift_mag values present at that edge.
- Throughput: one new operation per cycle. No handshake and no valid/ready signals; every cycle is an operation.
- The input-to-register path is purely combinational, with SHW mux levels. No internal state other than the Op register.
- Reset: on a rising clk edge with rst=1, Op <= 0, regardless of Ip and shift_mag.
- Reset has priority over the data load.
- First valid result appears on the first edge with rst=0.
- Reset is synchronous: asserting rst between edges does not change Op until the next rising edge.
- Deasserting rst mid-stream: the next edge loads the shift of the current inputs. No warm-up cycle.
- Changing inputs between edges has no effect on Op until the next edge.

## Test plan
- Reset: rst=1 for 2 cycles with Ip=8'hFF, shift_mag=3 -> Op=8'h00 after each edge. Release rst -> next edge Op=8'hF8.
- Directed shifts with Ip=8'b11010101, one per cycle, rst=0:
  - shift 0 -> 8'hD5
  - shift 1 -> 8'hAA
  - shift 2 -> 8'h54
  - shift 4 -> 8'h50
  - each appears one cycle after being applied.
- Remaining magnitudes with Ip=8'hD5:
  - shift 3 -> 8'hA8
  - shift 5 -> 8'hA0
  - shift 6 -> 8'h40
  - shift 7 -> 8'h80
- Single-bit walk: Ip=8'h01 with shift_mag 0..7 on consecutive cycles -> Op=8'h01, 02, 04, … 80, each one cycle late.
  - Back-to-back pipelining: no bubbles, no repeated values.
- Reset mid-stream: during the walk, assert rst for 1 cycle -> that edge gives Op=8'h00. The following edge gives the shift of the inputs then present.
- Random: 1000 random Ip/shift_mag pairs -> Op matches ((Ip<<shift_mag) & 8'hFF) delayed by one cycle.
